// File: rtl/lcd_serial_pkg.sv
// Shared types and timing constants for the LCD serial link.
package lcd_serial_pkg;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned BAUD             = 9600;
  localparam int unsigned CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_50,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lcd_uart_rx.sv
// 8N1 serial receiver for the LCD link; samples each bit at mid-bit from clk_50.
// Emits one-cycle rx_valid / frame_err strobes per frame.
module lcd_uart_rx
  import lcd_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt, busy_nxt;

  sync2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_50 (clk_50),
    .rst    (rst),
    .d      (rx_in),
    .q      (rx_s)
  );

  // State and output registers
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state, bit timing and strobe generation
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt   = START;
          bit_idx_nxt = 3'd0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HI;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      // Line stuck low after a bad stop bit: wait for idle before rearming
      WAIT_HI: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_lcd_uart_rx.sv
// Randomized self-checking bench for lcd_uart_rx against a frame-level timing model.
module tb_lcd_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int LAT = 2 + H + 9 * C + 1;  // rx_in start edge to strobe

  logic       clk_50 = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  logic       rx_def    [3];
  logic [7:0] def_data  [3];
  logic       def_valid [3];
  logic       def_ferr  [3];
  logic       def_busy  [3];
  int         def_cnt   [3];
  int         def_fcnt  [3];
  logic [7:0] def_last  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_data [$];
  int         got_cyc  [$];
  int         ferr_cyc [$];
  logic [7:0] exp_data [$];
  int         exp_cyc  [$];
  int         exp_ferr [$];
  logic [7:0] last_good;
  int         overlap = 0;
  int         wide = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  lcd_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_50(clk_50), .rst(rst), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy));

  lcd_uart_rx dut_nom (
    .clk_50(clk_50), .rst(rst), .rx_in(rx_def[0]), .rx_data(def_data[0]),
    .rx_valid(def_valid[0]), .frame_err(def_ferr[0]), .busy(def_busy[0]));
  lcd_uart_rx dut_slow (
    .clk_50(clk_50), .rst(rst), .rx_in(rx_def[1]), .rx_data(def_data[1]),
    .rx_valid(def_valid[1]), .frame_err(def_ferr[1]), .busy(def_busy[1]));
  lcd_uart_rx dut_fast (
    .clk_50(clk_50), .rst(rst), .rx_in(rx_def[2]), .rx_data(def_data[2]),
    .rx_valid(def_valid[2]), .frame_err(def_ferr[2]), .busy(def_busy[2]));

  // Output monitor, sampled on the inactive edge
  always @(negedge clk_50) begin
    if (rx_valid) begin
      got_data.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cyc.push_back(cyc);
    if (rx_valid && frame_err) overlap++;
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) wide++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    for (int i = 0; i < 3; i++) begin
      if (def_valid[i]) begin
        def_cnt[i]++;
        def_last[i] = def_data[i];
      end
      if (def_ferr[i]) def_fcnt[i]++;
    end
  end

  task automatic align();
    @(posedge clk_50);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    do @(negedge clk_50); while (cyc < c);
  endtask

  task automatic clear_q();
    got_data.delete(); got_cyc.delete(); ferr_cyc.delete();
    exp_data.delete(); exp_cyc.delete(); exp_ferr.delete();
  endtask

  // Bench-side 8N1 transmitter plus the expected-outcome model
  task automatic send_frame(input logic [7:0] b, input logic stop, output int c0);
    c0 = cyc;
    drive_bit(1'b0, C);
    for (int k = 0; k < 8; k++) drive_bit(b[k], C);
    drive_bit(stop, C);
    if (stop) begin
      exp_data.push_back(b);
      exp_cyc.push_back(c0 + LAT);
      last_good = b;
    end else begin
      exp_ferr.push_back(c0 + LAT);
    end
  endtask

  task automatic send_slow(input int idx, input logic [7:0] b, input int per);
    rx_def[idx] = 1'b0;
    repeat (per) @(posedge clk_50);
    for (int k = 0; k < 8; k++) begin
      rx_def[idx] = b[k];
      repeat (per) @(posedge clk_50);
    end
    rx_def[idx] = 1'b1;
    repeat (per) @(posedge clk_50);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    for (int i = 0; i < 3; i++) rx_def[i] = 1'b1;
    repeat (3) align();
    n_checks += 4;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    drive_bit(1'b1, 5);
  endtask

  task automatic test_clean_frame();
    int c0;
    clear_q();
    align();
    send_frame(8'hA5, 1'b1, c0);
    drive_bit(1'b1, 20);
    n_checks += 2;
    if (got_data.size() !== 1) begin n_fail++; $display("FAIL clean_pulse_count: got %0d expected 1", got_data.size()); end
    else begin
      n_checks += 2;
      if (got_data[0] !== 8'hA5) begin n_fail++; $display("FAIL clean_data: got %h expected a5", got_data[0]); end
      if (got_cyc[0] !== c0 + LAT) begin n_fail++; $display("FAIL clean_latency: got cycle %0d expected %0d", got_cyc[0], c0 + LAT); end
    end
    if (ferr_cyc.size() !== 0) begin n_fail++; $display("FAIL clean_frame_err: got %0d pulses expected 0", ferr_cyc.size()); end
  endtask

  task automatic test_glitch();
    int c0;
    clear_q();
    align();
    c0 = cyc;
    drive_bit(1'b0, 5);
    rx_in = 1'b1;
    wait_until(c0 + 10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    wait_until(c0 + 11);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop: got %b expected 0", busy); end
    align();
    drive_bit(1'b1, 200);
    n_checks++;
    if (got_data.size() + ferr_cyc.size() !== 0) begin
      n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", got_data.size() + ferr_cyc.size());
    end
  endtask

  task automatic test_frame_err();
    int c0;
    logic [7:0] prev;
    prev = last_good;
    clear_q();
    align();
    send_frame(8'h3C, 1'b0, c0);
    drive_bit(1'b0, 40);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held: got %b expected 1", busy); end
    rx_in = 1'b1;
    wait_until(c0 + 206);
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
    if (rx_data !== prev) begin n_fail++; $display("FAIL ferr_rx_data_kept: got %h expected %h", rx_data, prev); end
    if (got_data.size() !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", got_data.size()); end
    if (ferr_cyc.size() !== 1) begin n_fail++; $display("FAIL ferr_pulse_count: got %0d expected 1", ferr_cyc.size()); end
    else begin
      n_checks++;
      if (ferr_cyc[0] !== exp_ferr[0]) begin n_fail++; $display("FAIL ferr_timing: got %0d expected %0d", ferr_cyc[0], exp_ferr[0]); end
    end
    align();
    drive_bit(1'b1, 10);
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    clear_q();
    align();
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, c0);
    drive_bit(1'b1, 20);
    n_checks++;
    if (got_data.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", got_data.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks += 2;
        if (got_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_data[i], exp_data[i]); end
        if (got_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, got_cyc[i], exp_cyc[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    clear_q();
    align();
    drive_bit(1'b0, C);
    drive_bit(1'b1, C);
    drive_bit(1'b0, C / 2);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    rx_in = 1'b1;
    align();
    rst = 1'b0;
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
    drive_bit(1'b1, 20);
    n_checks++;
    if (got_data.size() + ferr_cyc.size() !== 0) begin n_fail++; $display("FAIL midrst_no_strobe: got %0d expected 0", got_data.size() + ferr_cyc.size()); end
    send_frame(8'h7E, 1'b1, c0);
    drive_bit(1'b1, 20);
    n_checks++;
    if (got_data.size() !== 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected 1", got_data.size()); end
    else begin
      n_checks++;
      if (got_data[0] !== 8'h7E) begin n_fail++; $display("FAIL midrst_next_data: got %h expected 7e", got_data[0]); end
    end
  endtask

  task automatic test_random();
    int c0;
    clear_q();
    align();
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, c0);
      drive_bit(1'b1, $urandom_range(0, 12));
    end
    drive_bit(1'b1, 20);
    n_checks++;
    if (got_data.size() !== exp_data.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        n_checks += 2;
        if (got_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_data[i], exp_data[i]); end
        if (got_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL rand_time[%0d]: got %0d expected %0d", i, got_cyc[i], exp_cyc[i]); end
      end
    end
  endtask

  task automatic test_strobe_rules();
    n_checks += 2;
    if (overlap !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap); end
    if (wide !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d wide strobes expected 0", wide); end
  endtask

  task automatic test_default_baud();
    int per [3];
    per[0] = 5208; per[1] = 5312; per[2] = 5104;
    for (int i = 0; i < 3; i++) begin def_cnt[i] = 0; def_fcnt[i] = 0; end
    align();
    fork
      send_slow(0, 8'h4C, per[0]);
      send_slow(1, 8'h4C, per[1]);
      send_slow(2, 8'h4C, per[2]);
    join
    repeat (50) align();
    for (int i = 0; i < 3; i++) begin
      n_checks += 3;
      if (def_cnt[i] !== 1) begin n_fail++; $display("FAIL baud%0d_count: got %0d expected 1", per[i], def_cnt[i]); end
      if (def_last[i] !== 8'h4C) begin n_fail++; $display("FAIL baud%0d_data: got %h expected 4c", per[i], def_last[i]); end
      if (def_fcnt[i] !== 0) begin n_fail++; $display("FAIL baud%0d_frame_err: got %0d expected 0", per[i], def_fcnt[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin def_cnt[i] = 0; def_fcnt[i] = 0; def_last[i] = 8'h00; end
    last_good = 8'h00;
    test_reset();
    test_clean_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_strobe_rules();
    test_default_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
